// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: entry layout, control states and word widths.
package fetch_queue_pkg;

    localparam int INSNBITS_SIZE = 32;
    localparam int GPR_SIZE      = 64;
    localparam int FQ_DEPTH      = 8;

    typedef struct packed {
        logic [INSNBITS_SIZE-1:0] insnbits;
        logic [GPR_SIZE-1:0]      pc;
    } fq_entry_t;

    typedef enum logic [1:0] {
        FQ_RUN,
        FQ_DRAIN,
        FQ_HALTED
    } fq_state_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and dispatch-side handshake bundle of the fetch queue.
interface fetch_queue_if #(
    parameter int DEPTH = 8
) ();
    import fetch_queue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     in_f_done;
    logic [INSNBITS_SIZE-1:0] in_f_insnbits;
    logic [GPR_SIZE-1:0]      in_f_pc;
    logic                     out_f_ready;
    logic                     in_rob_mispredict;
    logic                     out_d_done;
    logic [INSNBITS_SIZE-1:0] out_d_insnbits;
    logic [GPR_SIZE-1:0]      out_d_pc;
    logic                     in_d_ready;
    logic [CNT_W-1:0]         out_count;
    logic                     out_halted;

    // The master side is the pipeline around the queue (fetch, dispatch, ROB).
    modport master (
        output in_f_done, in_f_insnbits, in_f_pc, in_rob_mispredict, in_d_ready,
        input  out_f_ready, out_d_done, out_d_insnbits, out_d_pc, out_count, out_halted
    );

    modport slave (
        input  in_f_done, in_f_insnbits, in_f_pc, in_rob_mispredict, in_d_ready,
        output out_f_ready, out_d_done, out_d_insnbits, out_d_pc, out_count, out_halted
    );

endinterface

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port, one asynchronous read port.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fq_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fq_entry_t                rdata
);

    // No reset: the controller's occupancy count decides which entries are meaningful.
    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and dispatch with ROB flush and end-of-program drain/halt.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic        in_clk,
    input logic        in_rst_n,
    fetch_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    fq_state_t        state;

    logic      f_ready;
    logic      d_valid;
    logic      accept;
    logic      push;
    logic      pop;
    logic      end_marker;
    fq_entry_t wdata;
    fq_entry_t rdata;

    assign f_ready    = (count != CNT_W'(DEPTH)) && (state == FQ_RUN);
    assign d_valid    = (count != '0);
    assign accept     = bus.in_f_done && f_ready && !bus.in_rob_mispredict;
    assign push       = accept && (bus.in_f_insnbits != '0);
    assign end_marker = accept && (bus.in_f_insnbits == '0);
    assign pop        = d_valid && bus.in_d_ready && !bus.in_rob_mispredict;

    assign wdata.insnbits = bus.in_f_insnbits;
    assign wdata.pc       = bus.in_f_pc;

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (in_clk),
        .we    (push),
        .waddr (tail),
        .wdata (wdata),
        .raddr (head),
        .rdata (rdata)
    );

    // Pointers, occupancy and the run/drain/halt sequencing; a flush wins over any handshake.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= FQ_RUN;
        end else if (bus.in_rob_mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= FQ_RUN;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            case (state)
                FQ_RUN: begin
                    if (end_marker) begin
                        state <= FQ_DRAIN;
                    end
                end
                FQ_DRAIN: begin
                    if ((count == '0) || ((count == CNT_W'(1)) && pop)) begin
                        state <= FQ_HALTED;
                    end
                end
                FQ_HALTED: state <= FQ_HALTED;
                default:   state <= FQ_RUN;
            endcase
        end
    end

    assign bus.out_f_ready    = f_ready;
    assign bus.out_d_done     = d_valid;
    assign bus.out_d_insnbits = d_valid ? rdata.insnbits : '0;
    assign bus.out_d_pc       = d_valid ? rdata.pc : '0;
    assign bus.out_count      = count;
    assign bus.out_halted     = (state == FQ_HALTED);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

    localparam int            DEPTH = 8;
    localparam logic [31:0]   INSN  = 32'h8B02_0020;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic f_done, input logic [31:0] insn, input logic [63:0] pc,
                                 input logic d_ready, input logic mispredict);
        bus.in_f_done         = f_done;
        bus.in_f_insnbits     = insn;
        bus.in_f_pc           = pc;
        bus.in_d_ready        = d_ready;
        bus.in_rob_mispredict = mispredict;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        #3;
        checkOutput("rst_d_done", 64'(bus.out_d_done), 64'd0);
        checkOutput("rst_count", 64'(bus.out_count), 64'd0);
        checkOutput("rst_halted", 64'(bus.out_halted), 64'd0);
        checkOutput("rst_d_pc", bus.out_d_pc, 64'd0);
        checkOutput("rst_d_insn", 64'(bus.out_d_insnbits), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_f_ready", 64'(bus.out_f_ready), 64'd1);

        // Three pushes, then in-order pops.
        applyStimulus(1'b1, INSN, 64'h0, 1'b0, 1'b0);
        tick();
        checkOutput("lat_d_done", 64'(bus.out_d_done), 64'd1);
        checkOutput("lat_d_pc", bus.out_d_pc, 64'h0);
        applyStimulus(1'b1, INSN, 64'h4, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, INSN, 64'h8, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        checkOutput("p3_count", 64'(bus.out_count), 64'd3);
        checkOutput("p3_d_pc", bus.out_d_pc, 64'h0);
        checkOutput("p3_d_done", 64'(bus.out_d_done), 64'd1);
        checkOutput("p3_d_insn", 64'(bus.out_d_insnbits), 64'(INSN));
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("p3_pop_pc", bus.out_d_pc, 64'(4 * i));
            tick();
        end
        checkOutput("p3_empty_count", 64'(bus.out_count), 64'd0);
        checkOutput("p3_empty_done", 64'(bus.out_d_done), 64'd0);
        checkOutput("p3_empty_pc", bus.out_d_pc, 64'd0);

        // Fill to DEPTH, then a held push only enters after a pop frees a slot.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, INSN, 64'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("full_count", 64'(bus.out_count), 64'd8);
        checkOutput("full_f_ready", 64'(bus.out_f_ready), 64'd0);
        applyStimulus(1'b1, INSN, 64'h20, 1'b1, 1'b0);
        tick();
        checkOutput("full_pop_count", 64'(bus.out_count), 64'd7);
        checkOutput("full_pop_ready", 64'(bus.out_f_ready), 64'd1);
        checkOutput("full_pop_head", bus.out_d_pc, 64'h4);
        applyStimulus(1'b1, INSN, 64'h20, 1'b0, 1'b0);
        tick();
        checkOutput("full_refill_count", 64'(bus.out_count), 64'd8);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("full_drain_pc", bus.out_d_pc, 64'(4 * (i + 1)));
            tick();
        end
        checkOutput("full_drain_count", 64'(bus.out_count), 64'd0);

        // Streaming: push and pop every cycle, occupancy stays at one.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, INSN, 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
            tick();
            checkOutput("stream_count", 64'(bus.out_count), 64'd1);
            checkOutput("stream_pc", bus.out_d_pc, 64'h1000 + 64'(4 * i));
        end
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_end_count", 64'(bus.out_count), 64'd0);

        // Flush with five queued and a same-cycle push.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, INSN, 64'h40 + 64'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("fl_pre_count", 64'(bus.out_count), 64'd5);
        applyStimulus(1'b1, INSN, 64'h100, 1'b0, 1'b1);
        tick();
        checkOutput("fl_count", 64'(bus.out_count), 64'd0);
        checkOutput("fl_d_done", 64'(bus.out_d_done), 64'd0);
        checkOutput("fl_d_pc", bus.out_d_pc, 64'd0);
        applyStimulus(1'b1, INSN, 64'h200, 1'b0, 1'b0);
        tick();
        checkOutput("fl_new_head", bus.out_d_pc, 64'h200);
        checkOutput("fl_new_count", 64'(bus.out_count), 64'd1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("fl_pop_count", 64'(bus.out_count), 64'd0);

        // End marker: drain, halt, ignore fetch, then flush back to run.
        applyStimulus(1'b1, INSN, 64'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, INSN, 64'h4, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0, 64'h8, 1'b0, 1'b0);
        tick();
        checkOutput("end_f_ready", 64'(bus.out_f_ready), 64'd0);
        checkOutput("end_count", 64'(bus.out_count), 64'd2);
        checkOutput("end_halted_early", 64'(bus.out_halted), 64'd0);
        applyStimulus(1'b1, INSN, 64'hC, 1'b1, 1'b0);
        tick();
        checkOutput("drain_count", 64'(bus.out_count), 64'd1);
        checkOutput("drain_halted", 64'(bus.out_halted), 64'd0);
        tick();
        checkOutput("halt_flag", 64'(bus.out_halted), 64'd1);
        checkOutput("halt_d_done", 64'(bus.out_d_done), 64'd0);
        checkOutput("halt_f_ready", 64'(bus.out_f_ready), 64'd0);
        tick();
        checkOutput("halt_ignore_count", 64'(bus.out_count), 64'd0);
        checkOutput("halt_stays", 64'(bus.out_halted), 64'd1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        tick();
        checkOutput("unhalt_flag", 64'(bus.out_halted), 64'd0);
        checkOutput("unhalt_f_ready", 64'(bus.out_f_ready), 64'd1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        // Asynchronous reset between edges with four entries queued.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, INSN, 64'h80 + 64'(4 * i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        checkOutput("arst_pre_count", 64'(bus.out_count), 64'd4);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_d_done", 64'(bus.out_d_done), 64'd0);
        checkOutput("arst_count", 64'(bus.out_count), 64'd0);
        checkOutput("arst_halted", 64'(bus.out_halted), 64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        checkOutput("arst_f_ready", 64'(bus.out_f_ready), 64'd1);
        checkOutput("arst_post_count", 64'(bus.out_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction buffer between fetch (producer) and dispatch (consumer).
- Absorbs fetch/dispatch rate mismatch with a valid/ready handshake on both sides.
- Flushes all buffered instructions on ROB mispredict.
- Detects the end-of-program marker (all-zero insnbits) and reports a halt once drained.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of 2 and >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived).

Ports:
- in_clk  input  1  core clock; all state updates on the rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_f_done  input  1  fetch presents a valid instruction.
- in_f_insnbits  input  `INSNBITS_SIZE (32)  instruction word from fetch.
- in_f_pc  input  `GPR_SIZE (64)  PC of that instruction.
- out_f_ready  output  1  queue can accept this cycle.
- in_rob_mispredict  input  1  flush request from ROB.
- out_d_done  output  1  head entry valid toward dispatch.
- out_d_insnbits  output  `INSNBITS_SIZE  head instruction word.
- out_d_pc  output  `GPR_SIZE  head PC.
- in_d_ready  input  1  dispatch consumes the head this cycle.
- out_count  output  CNT_W  current occupancy, 0..DEPTH.
- out_halted  output  1  end marker accepted and queue fully drained.

Behaviour:
- Reset (in_rst_n low, asynchronous):
  - Head pointer, tail pointer and count go to 0; state goes to RUN.
  - Outputs: out_d_done=0, out_d_insnbits=0, out_d_pc=0, out_count=0, out_halted=0, out_f_ready=1 (immediately after reset release).
  - Reset asserted mid-operation discards all contents; there is no partial state.
- Push: occurs when in_f_done && out_f_ready && insnbits != 0 && !in_rob_mispredict. Writes the entry at the tail, and the tail increments modulo DEPTH.
- Pop: occurs when out_d_done && in_d_ready && !in_rob_mispredict. Head increments modulo DEPTH.
- Head outputs are show-ahead:
  - out_d_insnbits and out_d_pc are driven from storage[head] whenever count > 0.
  - When count == 0 they are driven to 0.
  - out_d_done = (count != 0).
- Latency: fetch-to-dispatch is 1 cycle. A word pushed at edge N is visible at out_d_* after edge N. There is no combinational bypass from in_f to out_d.
- out_f_ready = (count != DEPTH) && state == RUN. It is combinational from state only and does not depend on in_d_ready; when full, there is no push even if a pop occurs the same cycle.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Empty: pop is impossible because out_d_done=0.
- Full: out_f_ready=0; fetch must hold its instruction.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer equality.
- Flush (in_rob_mispredict=1 at an edge):
  - Head, tail and count go to 0; state goes to RUN.
  - Any same-cycle push or pop is discarded.
  - out_d_done=0 on the following cycle. Flush has priority over everything except reset.
- State machine:
  - RUN: accepting a word with insnbits==0 (in_f_done && out_f_ready) transitions to DRAIN. The zero word is NOT enqueued.
  - DRAIN: out_f_ready=0; pops continue. Transitions to HALTED when count reaches 0, i.e. the edge on which the last pop occurs, or the next edge if already empty.
  - HALTED: out_halted=1, out_f_ready=0, out_d_done=0.
  - Flush from DRAIN or HALTED returns to RUN.
- out_count is registered and updates on the same edge as the pointers.

Decomposition:
- Shared package (data_structures.sv):
  - `INSNBITS_SIZE and `GPR_SIZE (existing).
  - New fq_entry_t packed struct {insnbits, pc}.
  - New fq_state_t enum {FQ_RUN, FQ_DRAIN, FQ_HALTED}.
- Sub-module fq_storage: DEPTH x fq_entry_t register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). It has no reset; validity is tracked by count.
- Control (pointers, count, FSM) stays in fetch_queue.

Test Plan:
- Reset then push PCs 0x0,0x4,0x8 (insn 0x8B020020) with in_d_ready=0 -> out_count=3, out_d_pc=0x0, out_d_done=1. Then raise in_d_ready for 3 cycles -> PCs pop in order 0x0,0x4,0x8, and count=0 afterwards.
- Push DEPTH=8 entries with in_d_ready=0 -> out_f_ready=0 at count=8. Then hold in_f_done with PC 0x20 and pop once -> 0x20 enters only on the cycle after the pop.
- Steady-state: in_f_done=1 and in_d_ready=1 every cycle for 20 cycles (PC +4 each) -> count stays 1, every PC emerges exactly once in order, and pointers wrap twice without loss.
- With 5 entries queued, assert in_rob_mispredict together with a push of PC 0x100 -> next cycle count=0, out_d_done=0, and 0x100 absent. Then push 0x200 -> 0x200 is the head.
- Push PC 0x0, 0x4, then insnbits=0 at 0x8 -> out_f_ready drops and count=2. After 2 pops out_halted=1; further in_f_done is ignored. Then mispredict -> out_halted=0, out_f_ready=1.
- Deassert in_rst_n asynchronously between edges with 4 entries queued -> out_d_done, out_count and out_halted go to 0 immediately, without waiting for in_clk.
